// File: rtl/avgpool2d_bwd.sv
// Streaming average-pool backward: accumulates rounded grad/(K*K) over each
// pooling window into an input-gradient buffer, then drains it in raster order.
module avgpool2d_bwd #(
  parameter int    CH        = 1,
  parameter int    IN_H      = 2,
  parameter int    IN_W      = 2,
  parameter int    K         = 2,
  parameter int    STRIDE    = 2,
  parameter int    WIDTH     = 16,
  parameter string precision = "Q8.8"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);
  // state | meaning
  // ACCUM | accepting output-gradient elements, accumulating into the buffer
  // DRAIN | streaming the saturated buffer out, no input accepted

  localparam int OUT_H = (IN_H - K) / STRIDE + 1;
  localparam int OUT_W = (IN_W - K) / STRIDE + 1;
  localparam int DENOM = K * K;
  localparam int N_OUT = CH * IN_H * IN_W;
  localparam int KS    = (K + STRIDE - 1) / STRIDE;
  localparam int ACC_W = WIDTH + $clog2(KS * KS) + 1;
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int HW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int WW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CH - 1);
  localparam logic [HW-1:0] H_LAST = HW'(OUT_H - 1);
  localparam logic [WW-1:0] W_LAST = WW'(OUT_W - 1);
  localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           ic, ic_nxt;
  logic [HW-1:0]           ioh, ioh_nxt;
  logic [WW-1:0]           iow, iow_nxt;
  logic [OW-1:0]           oidx, oidx_nxt;
  logic signed [ACC_W-1:0] acc     [N_OUT];
  logic signed [ACC_W-1:0] acc_nxt [N_OUT];
  logic                    in_fire, out_fire, in_last, drain_done;
  logic                    neg;
  logic [WIDTH:0]          ext, mag;
  logic [WIDTH+1:0]        rsum, quo;
  logic signed [ACC_W-1:0] s_abs, s;
  int                      bh, bw;

  function automatic logic [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-WIDTH:0] top;
    top = a[ACC_W-1:WIDTH-1];
    if ((&top) || ~(|top)) return a[WIDTH-1:0];
    else if (a[ACC_W-1])   return {1'b1, {(WIDTH-1){1'b0}}};
    else                   return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Round half away from zero; magnitude is one bit wider so the most
  // negative input divides exactly.
  always_comb begin
    neg   = in_data[WIDTH-1];
    ext   = {in_data[WIDTH-1], in_data};
    mag   = neg ? -ext : ext;
    rsum  = {1'b0, mag} + (WIDTH+2)'(DENOM / 2);
    quo   = rsum / (WIDTH+2)'(DENOM);
    s_abs = ACC_W'(quo);
    s     = neg ? -s_abs : s_abs;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = (state == ACCUM);
    out_valid  = (state == DRAIN);
    in_fire    = in_valid & in_ready;
    out_fire   = out_valid & out_ready;
    in_last    = (ic == C_LAST) && (ioh == H_LAST) && (iow == W_LAST);
    drain_done = out_fire && (oidx == O_LAST);
    ic_nxt     = ic;
    ioh_nxt    = ioh;
    iow_nxt    = iow;
    oidx_nxt   = '0;
    case (state)
      ACCUM: begin
        if (in_fire) begin
          iow_nxt = (iow == W_LAST) ? '0 : iow + 1'b1;
          if (iow == W_LAST) begin
            ioh_nxt = (ioh == H_LAST) ? '0 : ioh + 1'b1;
            if (ioh == H_LAST) ic_nxt = (ic == C_LAST) ? '0 : ic + 1'b1;
          end
          if (in_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        oidx_nxt = oidx;
        if (out_fire) oidx_nxt = (oidx == O_LAST) ? '0 : oidx + 1'b1;
        if (drain_done) begin
          state_nxt = ACCUM;
          ic_nxt    = '0;
          ioh_nxt   = '0;
          iow_nxt   = '0;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Every buffer cell covered by the current window takes s in one cycle.
  always_comb begin
    bh = int'(ioh) * STRIDE;
    bw = int'(iow) * STRIDE;
    for (int p = 0; p < N_OUT; p++) begin
      acc_nxt[p] = acc[p];
      if (drain_done)
        acc_nxt[p] = '0;
      else if (in_fire && (int'(ic) == p / (IN_H * IN_W)) &&
               ((p / IN_W) % IN_H >= bh) && ((p / IN_W) % IN_H < bh + K) &&
               (p % IN_W >= bw) && (p % IN_W < bw + K))
        acc_nxt[p] = acc[p] + s;
    end
  end

  // out_data is loaded from the next buffer image so the final accumulation
  // is already visible in element 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      ic       <= '0;
      ioh      <= '0;
      iow      <= '0;
      oidx     <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      for (int p = 0; p < N_OUT; p++) acc[p] <= '0;
    end else begin
      state    <= state_nxt;
      ic       <= ic_nxt;
      ioh      <= ioh_nxt;
      iow      <= iow_nxt;
      oidx     <= oidx_nxt;
      out_data <= (state_nxt == DRAIN) ? sat(acc_nxt[oidx_nxt]) : '0;
      out_last <= (state_nxt == DRAIN) && (oidx_nxt == O_LAST);
      for (int p = 0; p < N_OUT; p++) acc[p] <= acc_nxt[p];
    end
  end

endmodule

// File: tb/tb_avgpool2d_bwd.sv
// Bench for avgpool2d_bwd: three configurations checked every cycle against
// an array-based pooling-gradient model, plus literal frame expectations.
module tb_avgpool2d_bwd;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [15:0] in_data [3];
  wire  [2:0]  in_ready, out_valid, out_last;
  wire  [15:0] out_data [3];

  avgpool2d_bwd #(.CH(1), .IN_H(2), .IN_W(2), .K(2), .STRIDE(2), .WIDTH(16), .precision("Q8.8")) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]));
  avgpool2d_bwd #(.CH(1), .IN_H(3), .IN_W(3), .K(2), .STRIDE(1), .WIDTH(16), .precision("Q8.8")) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]));
  avgpool2d_bwd #(.CH(2), .IN_H(4), .IN_W(4), .K(2), .STRIDE(2), .WIDTH(16), .precision("Q8.8")) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .out_last(out_last[2]));

  int c_ch[3] = '{1, 1, 2};
  int c_ih[3] = '{2, 3, 4};
  int c_iw[3] = '{2, 3, 4};
  int c_k [3] = '{2, 2, 2};
  int c_s [3] = '{2, 1, 2};

  int n_cmp = 0, n_bad = 0;
  int ph[3], ic[3], oc[3], frames[3], lasts[3];
  int macc[3][64], expv[3][64], cap[3][64];
  bit prev_stall[3];
  logic [15:0] prev_data[3];
  logic prev_last[3];
  bit bp = 0;

  function automatic int oh_of(int g); return (c_ih[g] - c_k[g]) / c_s[g] + 1; endfunction
  function automatic int ow_of(int g); return (c_iw[g] - c_k[g]) / c_s[g] + 1; endfunction
  function automatic int n_in(int g);  return c_ch[g] * oh_of(g) * ow_of(g); endfunction
  function automatic int n_out(int g); return c_ch[g] * c_ih[g] * c_iw[g]; endfunction

  task automatic chk(string name, int idx, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic model_reset(int g);
    ph[g] = 0; ic[g] = 0; oc[g] = 0; prev_stall[g] = 0;
    for (int p = 0; p < 64; p++) macc[g][p] = 0;
  endtask

  // Gradient element i lands on its whole KxK window, divided by K*K with
  // round-half-away-from-zero; outputs are the clamped window sums.
  task automatic model_accept(int g, int v);
    int d, sv, per, c, r, y, x, e;
    d   = c_k[g] * c_k[g];
    sv  = (v < 0) ? -((-v + d / 2) / d) : (v + d / 2) / d;
    per = oh_of(g) * ow_of(g);
    c   = ic[g] / per;
    r   = ic[g] % per;
    y   = (r / ow_of(g)) * c_s[g];
    x   = (r % ow_of(g)) * c_s[g];
    for (int kh = 0; kh < c_k[g]; kh++)
      for (int kw = 0; kw < c_k[g]; kw++)
        macc[g][(c * c_ih[g] + y + kh) * c_iw[g] + x + kw] += sv;
    ic[g]++;
    if (ic[g] == n_in(g)) begin
      for (int p = 0; p < n_out(g); p++) begin
        e = macc[g][p];
        if (e > 32767) e = 32767;
        if (e < -32768) e = -32768;
        expv[g][p] = e & 16'hFFFF;
      end
      ph[g] = 1; oc[g] = 0; ic[g] = 0; lasts[g] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        model_reset(g);
      end else begin
        chk("in_ready", g, int'(in_ready[g]), int'(ph[g] == 0));
        chk("out_valid", g, int'(out_valid[g]), int'(ph[g] == 1));
        if (ph[g] == 1) begin
          chk("out_data", g * 100 + oc[g], int'(out_data[g]), expv[g][oc[g]]);
          chk("out_last", g * 100 + oc[g], int'(out_last[g]), int'(oc[g] == n_out(g) - 1));
          if (prev_stall[g]) begin
            chk("stall_data", g, int'(out_data[g]), int'(prev_data[g]));
            chk("stall_last", g, int'(out_last[g]), int'(prev_last[g]));
          end
          prev_data[g] = out_data[g];
          prev_last[g] = out_last[g];
          if (out_ready[g]) begin
            prev_stall[g] = 0;
            cap[g][oc[g]] = int'(out_data[g]);
            if (out_last[g]) lasts[g]++;
            oc[g]++;
            if (oc[g] == n_out(g)) begin
              frames[g]++;
              model_reset(g);
            end
          end else begin
            prev_stall[g] = 1;
          end
        end else begin
          prev_stall[g] = 0;
          if (in_valid[g]) model_accept(g, int'($signed(in_data[g])));
        end
      end
    end
  end

  initial begin
    for (int g = 0; g < 3; g++) out_ready[g] = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) out_ready[g] = bp ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic send(int g, int v, bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) begin
      in_data[g] = 16'($urandom); @(posedge clk); #1;
    end
    in_valid[g] = 1'b1;
    in_data[g]  = 16'(v);
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
    in_data[g]  = 16'($urandom);
  endtask

  task automatic wait_frame(int g, int f0);
    int n = 0;
    while (frames[g] == f0 && n < 3000) begin @(posedge clk); #1; n++; end
    chk("frame_done", g, int'(frames[g] != f0), 1);
  endtask

  task automatic run_const(int g, int v, int n);
    int f0 = frames[g];
    repeat (n) send(g, v, 0);
    wait_frame(g, f0);
    chk("single_last", g, lasts[g], 1);
  endtask

  task automatic check_cap(int g, string name, input int q[$]);
    foreach (q[i]) chk(name, i, cap[g][i], q[i]);
  endtask

  initial begin
    int f0, n;
    in_valid = '0;
    for (int g = 0; g < 3; g++) in_data[g] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_out_data", g, int'(out_data[g]), 0);
      chk("rst_out_last", g, int'(out_last[g]), 0);
      chk("rst_in_ready", g, int'(in_ready[g]), 1);
      chk("rst_out_valid", g, int'(out_valid[g]), 0);
    end
    @(posedge clk); #1;

    run_const(0, 'h0400, 1);
    check_cap(0, "t_0400", '{'h0100, 'h0100, 'h0100, 'h0100});
    run_const(0, 'hFFFD, 1);
    check_cap(0, "t_neg3", '{'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF});
    run_const(0, 'hFFFE, 1);
    check_cap(0, "t_neg2", '{'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF});
    run_const(0, 'h8000, 1);
    check_cap(0, "t_min", '{'hE000, 'hE000, 'hE000, 'hE000});

    run_const(1, 'h0400, 4);
    check_cap(1, "t_ovl", '{'h0100, 'h0200, 'h0100, 'h0200, 'h0400, 'h0200, 'h0100, 'h0200, 'h0100});
    run_const(1, 'h7FFF, 4);
    check_cap(1, "t_sat", '{'h2000, 'h4000, 'h2000, 'h4000, 'h7FFF, 'h4000, 'h2000, 'h4000, 'h2000});

    bp = 1;
    for (int fr = 0; fr < 4; fr++) begin
      f0 = frames[2];
      for (int i = 0; i < 8; i++)
        send(2, (i == fr) ? 'h8000 : ((i == fr + 1) ? 'h7FFF : int'($urandom_range(0, 65535))), 1);
      wait_frame(2, f0);
      chk("bp_single_last", 2, lasts[2], 1);
    end
    for (int fr = 0; fr < 3; fr++) begin
      f0 = frames[1];
      for (int i = 0; i < 4; i++) send(1, int'($urandom_range(0, 65535)), 1);
      wait_frame(1, f0);
    end
    bp = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) send(1, 'h7FFF, 0);
    n = 0;
    while (oc[1] < 2 && n < 100) begin @(posedge clk); #1; n++; end
    chk("abort_reach", 1, oc[1], 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 1, int'(out_valid[1]), 0);
    chk("abort_in_ready", 1, int'(in_ready[1]), 1);
    @(posedge clk); #1;
    run_const(1, 'h0400, 4);
    check_cap(1, "t_fresh", '{'h0100, 'h0200, 'h0100, 'h0200, 'h0400, 'h0200, 'h0100, 'h0200, 'h0100});

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
